// File: rtl/boom_core_param.sv
`default_nettype none
// ============================================================================
// Module   : boom_core_param
// Brief    : Parametrised password-bomb game core (arm, countdown, defuse).
//            Optional macro BOOM_HINT_EN adds a matching-bit-count hint output.
// Revision : 1.0
// ============================================================================
module boom_core_param #(
  parameter int PW_W      = 7,
  parameter int MAX_TRIES = 3,
  parameter int COUNT_SEC = 30,
  parameter int PENALTY   = 5,
  parameter int TICK_DIV  = 1000000,
  parameter int BUZZ_CYC  = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 power,
  input  logic                 start,
  input  logic                 confirm,
  input  logic [PW_W-1:0]      pw_in,
  output logic [2:0]           state,
  output logic [7:0]           time_bcd,
  output logic [3:0]           tries_left,
  output logic [MAX_TRIES-1:0] led_tries,
  output logic                 wrong,
  output logic                 buzz
`ifdef BOOM_HINT_EN
  ,
  output logic [$clog2(PW_W+1)-1:0] hint
`endif
);

  localparam int c_TW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SET      = 3'd1,
    ST_ARMED    = 3'd2,
    ST_DEFUSED  = 3'd3,
    ST_EXPLODED = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [6:0]      r_time, w_time_nxt;
  logic [3:0]      r_tries, w_tries_nxt;
  logic [PW_W-1:0] r_pw, w_pw_nxt;
  logic [c_TW-1:0] r_tick, w_tick_nxt;
  logic            r_start_q, r_confirm_q;
  logic            r_wrong, w_wrong_nxt;

  logic            w_start_ev, w_conf_ev, w_match, w_tick_wrap;
  logic [7:0]      w_sub;
  logic [6:0]      w_time_pen;

  assign w_start_ev  = start & ~r_start_q;
  assign w_conf_ev   = confirm & ~r_confirm_q;
  assign w_match     = (pw_in == r_pw);
  assign w_tick_wrap = (r_tick == c_TW'(TICK_DIV - 1));

  // A wrong guess landing on a tick pays both the penalty and the tick second.
  assign w_sub      = 8'(PENALTY) + {7'd0, w_tick_wrap};
  assign w_time_pen = ({1'b0, r_time} > w_sub) ? (r_time - w_sub[6:0]) : 7'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_OFF;
      r_time      <= '0;
      r_tries     <= '0;
      r_pw        <= '0;
      r_tick      <= '0;
      r_start_q   <= 1'b0;
      r_confirm_q <= 1'b0;
      r_wrong     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_time      <= w_time_nxt;
      r_tries     <= w_tries_nxt;
      r_pw        <= w_pw_nxt;
      r_tick      <= w_tick_nxt;
      r_start_q   <= start;
      r_confirm_q <= confirm;
      r_wrong     <= w_wrong_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_tries_nxt = r_tries;
    w_pw_nxt    = r_pw;
    w_tick_nxt  = r_tick;
    w_wrong_nxt = 1'b0;
    if (!power) begin
      w_state_nxt = ST_OFF;
      w_time_nxt  = '0;
      w_tries_nxt = '0;
      w_tick_nxt  = '0;
    end else begin
      case (r_state)
        ST_OFF: w_state_nxt = ST_SET;
        ST_SET: begin
          if (w_start_ev && (pw_in != '0)) begin
            w_pw_nxt    = pw_in;
            w_time_nxt  = 7'(COUNT_SEC);
            w_tries_nxt = 4'(MAX_TRIES);
            w_tick_nxt  = '0;
            w_state_nxt = ST_ARMED;
          end
        end
        ST_ARMED: begin
          w_tick_nxt = w_tick_wrap ? '0 : r_tick + 1'b1;
          if (w_conf_ev && w_match) begin
            w_state_nxt = ST_DEFUSED;
          end else if (w_conf_ev) begin
            w_wrong_nxt = 1'b1;
            w_tries_nxt = r_tries - 4'd1;
            w_time_nxt  = w_time_pen;
            if ((r_tries == 4'd1) || (w_time_pen == 7'd0))
              w_state_nxt = ST_EXPLODED;
          end else if (w_tick_wrap) begin
            w_time_nxt = r_time - 7'd1;
            if (r_time == 7'd1)
              w_state_nxt = ST_EXPLODED;
          end
        end
        ST_DEFUSED, ST_EXPLODED: begin
          if (w_start_ev)
            w_state_nxt = ST_SET;
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

`ifdef BOOM_HINT_EN
  localparam int c_HW = $clog2(PW_W + 1);

  logic [c_HW-1:0] r_hint, w_hint_nxt, w_same;

  always_comb begin
    w_same = '0;
    for (int i = 0; i < PW_W; i++)
      if (pw_in[i] == r_pw[i])
        w_same = w_same + 1'b1;
  end

  // Hint lives only while the round is armed; an exploding guess clears it too.
  always_comb begin
    w_hint_nxt = r_hint;
    if (w_state_nxt != ST_ARMED)
      w_hint_nxt = '0;
    else if (w_wrong_nxt)
      w_hint_nxt = w_same;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_hint <= '0;
    else
      r_hint <= w_hint_nxt;
  end

  assign hint = r_hint;
`endif

  assign state      = r_state;
  assign tries_left = r_tries;
  assign wrong      = r_wrong;
  assign time_bcd   = {4'(r_time / 7'd10), 4'(r_time % 7'd10)};
  assign buzz       = ((r_state == ST_ARMED) && (r_tick < c_TW'(BUZZ_CYC))) ||
                      (r_state == ST_EXPLODED);

  for (genvar i = 0; i < MAX_TRIES; i++) begin : g_led
    assign led_tries[i] = (r_tries > 4'(i));
  end

endmodule
`default_nettype wire

// File: tb/tb_boom_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_boom_core_param
// Brief    : Self-checking bench for boom_core_param against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_boom_core_param;

  localparam int PW_W = 7, MAX_TRIES = 3, COUNT_SEC = 30, PENALTY = 5;
  localparam int TICK_DIV = 10, BUZZ_CYC = 3;
  localparam logic [6:0] PW = 7'b1010110;

  logic clk = 1'b0, rst = 1'b1, power = 1'b0, start = 1'b0, confirm = 1'b0;
  logic [6:0] pw_in = '0;
  logic [2:0] state;
  logic [7:0] time_bcd;
  logic [3:0] tries_left;
  logic [2:0] led_tries;
  logic       wrong, buzz;

  int checks = 0, errors = 0;

  // Reference model: game state as plain integers.
  int m_state, m_time, m_tries, m_phase, m_pass;
  bit m_wrong, m_sp, m_cp;

  boom_core_param #(
    .PW_W(PW_W), .MAX_TRIES(MAX_TRIES), .COUNT_SEC(COUNT_SEC),
    .PENALTY(PENALTY), .TICK_DIV(TICK_DIV), .BUZZ_CYC(BUZZ_CYC)
  ) dut (
    .clk(clk), .rst(rst), .power(power), .start(start), .confirm(confirm),
    .pw_in(pw_in), .state(state), .time_bcd(time_bcd), .tries_left(tries_left),
    .led_tries(led_tries), .wrong(wrong), .buzz(buzz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_time = 0; m_tries = 0; m_phase = 0; m_pass = 0;
    m_wrong = 0; m_sp = 0; m_cp = 0;
  endtask

  task automatic model_step();
    bit sev, cev, tick;
    int t;
    sev = start && !m_sp;
    cev = confirm && !m_cp;
    m_wrong = 0;
    if (!power) begin
      m_state = 0; m_time = 0; m_tries = 0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: if (sev && pw_in != 0) begin
             m_pass = pw_in; m_time = COUNT_SEC; m_tries = MAX_TRIES;
             m_phase = 0; m_state = 2;
           end
        2: begin
          tick = (m_phase == TICK_DIV - 1);
          m_phase = (m_phase + 1) % TICK_DIV;
          if (cev && pw_in == m_pass) m_state = 3;
          else if (cev) begin
            m_wrong = 1;
            m_tries = m_tries - 1;
            t = m_time - PENALTY - (tick ? 1 : 0);
            m_time = (t < 0) ? 0 : t;
            if (m_tries == 0 || m_time == 0) m_state = 4;
          end else if (tick) begin
            m_time = m_time - 1;
            if (m_time == 0) m_state = 4;
          end
        end
        default: if (sev) m_state = 1;
      endcase
    end
    m_sp = start;
    m_cp = confirm;
  endtask

  task automatic compare_all();
    check("state", state, m_state);
    check("time_bcd", time_bcd, ((m_time / 10) << 4) | (m_time % 10));
    check("tries_left", tries_left, m_tries);
    check("led_tries", led_tries, (1 << m_tries) - 1);
    check("wrong", wrong, m_wrong);
    check("buzz", buzz, (m_state == 4) || (m_state == 2 && m_phase < BUZZ_CYC));
  endtask

  // Drive one cycle of inputs from a negedge, advance the model, check at the next negedge.
  task automatic cyc(input logic p, input logic s, input logic c, input logic [6:0] w);
    power = p; start = s; confirm = c; pw_in = w;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_state", state, 0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic go_armed(input logic [6:0] w);
    if (m_state == 3 || m_state == 4) begin
      cyc(1, 1, 0, w);
      cyc(1, 0, 0, w);
    end
    if (m_state == 0) cyc(1, 0, 0, w);
    if (m_state == 2) begin
      cyc(0, 0, 0, w);
      cyc(1, 0, 0, w);
    end
    cyc(1, 1, 0, w);
    check("go_armed", state, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [7:0] tfreeze;
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Reset / power-up
    cyc(0, 0, 0, 0);
    check("off_state", state, 0);
    cyc(1, 0, 0, 0);
    check("set_state", state, 1);

    // Arming: zero password ignored, then valid password
    cyc(1, 1, 0, 0);
    check("zero_pw_ignored", state, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, PW);
    check("arm_state", state, 2);
    check("arm_time", time_bcd, 8'h30);
    check("arm_tries", tries_left, 3);
    check("arm_led", led_tries, 3'b111);
    nb = 0;
    for (int n = 0; n < 10; n++) begin
      cyc(1, 0, 0, PW);
      nb += int'(buzz);
    end
    check("first_tick_time", time_bcd, 8'h29);
    check("buzz_per_tick", nb, 3);

    // Wrong guesses
    cyc(1, 0, 1, 7'b1011100);
    check("wrong_pulse", wrong, 1);
    check("wrong_tries", tries_left, 2);
    check("wrong_time", time_bcd, 8'h24);
    cyc(1, 0, 0, 7'b1011100);
    check("wrong_one_cycle", wrong, 0);
    cyc(1, 0, 1, 7'b1011100);
    cyc(1, 0, 0, 7'b1011100);
    cyc(1, 0, 1, 7'b1011100);
    check("explode_state", state, 4);
    cyc(1, 0, 0, 7'b1011100);
    cyc(1, 0, 0, 7'b1011100);
    check("explode_buzz", buzz, 1);

    // Defuse, freeze, restart
    go_armed(PW);
    cyc(1, 0, 0, PW);
    cyc(1, 0, 1, PW);
    check("defuse_state", state, 3);
    tfreeze = time_bcd;
    for (int n = 0; n < 15; n++) cyc(1, 0, 0, PW);
    check("defuse_frozen", time_bcd, tfreeze);
    cyc(1, 1, 0, PW);
    check("restart_set", state, 1);
    cyc(1, 0, 0, PW);

    // Timeout: explode exactly 300 cycles after arming
    go_armed(PW);
    for (int n = 0; n < 299; n++) cyc(1, 0, 0, PW);
    check("pre_timeout_state", state, 2);
    cyc(1, 0, 0, PW);
    check("timeout_state", state, 4);
    check("timeout_time", time_bcd, 8'h00);

    // Correct guess on the final tick
    go_armed(PW);
    for (int n = 0; n < 400 && !(m_time == 1 && m_phase == TICK_DIV - 1); n++)
      cyc(1, 0, 0, PW);
    check("reach_last_tick", (m_time == 1 && m_phase == TICK_DIV - 1), 1);
    cyc(1, 0, 1, PW);
    check("last_tick_defuse", state, 3);
    check("last_tick_time", time_bcd, 8'h01);

    // Wrong guess with three seconds left
    go_armed(PW);
    for (int n = 0; n < 400 && !(m_time == 8 && m_phase < 5); n++)
      cyc(1, 0, 0, PW);
    check("reach_t8", (m_time == 8 && m_phase < 5), 1);
    cyc(1, 0, 1, 7'b0000001);
    check("t3_time", time_bcd, 8'h03);
    cyc(1, 0, 0, 7'b0000001);
    cyc(1, 0, 1, 7'b0000001);
    check("t0_time", time_bcd, 8'h00);
    check("t0_state", state, 4);

    // Power drop while armed
    go_armed(PW);
    for (int n = 0; n < 4; n++) cyc(1, 0, 0, PW);
    cyc(0, 0, 0, PW);
    check("power_off_state", state, 0);

    // Async reset while armed, confirm held through release
    go_armed(PW);
    for (int n = 0; n < 4; n++) cyc(1, 0, 0, PW);
    confirm = 1'b1;
    pw_in = 7'b0000011;
    async_reset();
    for (int n = 0; n < 6; n++) begin
      cyc(1, 0, 1, 7'b0000011);
      check("held_confirm_no_wrong", wrong, 0);
    end
    cyc(1, 0, 0, 7'b0000011);

    // Randomised play
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        cyc($urandom_range(0, 199) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) ? 7'(m_pass) : 7'($urandom_range(0, 127)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
